// File: rtl/filter_pkg.sv
// Shared definitions for the filter read/write address handlers.
// The state encodings are chosen to match the read-side handler.
package filter_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StDone = 3'b100
  } state_e;

  localparam int unsigned DefaultAddrStride = 4;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry register FIFO. Entry 0 is always the head.
// It also exposes the next-cycle count and head, so that the consumer's outputs can be registered.
module sync_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_next_o,
  output logic [Width-1:0] head_next_o
);

  logic [Width-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i && ((count_q != 2'd2) || pop_i);
    do_pop  = pop_i && (count_q != 2'd0);
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = data_i;
        else                 mem1_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem0_d = data_i;
        end else begin
          mem0_d = mem1_q;
          mem1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= '0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign full_o       = (count_q == 2'd2);
  assign empty_o      = (count_q == 2'd0);
  assign count_next_o = count_d;
  assign head_next_o  = mem0_d;

endmodule

// File: rtl/result_writer.sv
// Writes filtered pixels to the output image in raster order.
// All outputs are registered from next-state values.
module result_writer
  import filter_pkg::*;
#(
  parameter int unsigned WORD        = 8,
  parameter int unsigned ADDR_STRIDE = DefaultAddrStride,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] h,
  input  logic [WORD-1:0] w,
  input  logic [31:0]     base_addr,
  input  logic            start,
  input  logic            res_valid,
  input  logic [WORD-1:0] res_data,
  output logic            res_ready,
  output logic [31:0]     address,
  output logic [31:0]     wdata,
  output logic            w_en,
  input  logic            mem_ready,
  output logic            row_end,
  output logic            busy,
  output logic            done
);

  state_e              state_q, state_d;
  logic [WORD-1:0]     h_q, h_d, w_q, w_d, x_q, x_d, y_q, y_d;
  logic [31:0]         base_q, base_d, idx_q, idx_d;
  logic [2*WORD-1:0]   acc_q, acc_d, total;
  logic                res_ready_q, res_ready_d, w_en_q, w_en_d;
  logic                row_end_q, row_end_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]         address_q, address_d, wdata_q, wdata_d;
  logic                push, pop, last_write, launch;
  logic                fifo_full, fifo_empty;
  logic [1:0]          fifo_count_next;
  logic [WORD-1:0]     fifo_head_next;

  assign push       = res_valid && res_ready_q && !fifo_full;
  assign pop        = w_en_q && mem_ready && !fifo_empty;
  assign launch     = (state_q == StIdle) && start;
  assign last_write = pop && (32'(total) == idx_q + 32'd1);

  sync_fifo2 #(
    .Width (WORD)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       (res_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_next_o (fifo_count_next),
    .head_next_o  (fifo_head_next)
  );

  // Non-positive dimensions mean an empty frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (h[WORD-1] || (h == '0) || w[WORD-1] || (w == '0)) state_d = StDone;
          else                                                  state_d = StRun;
        end
      end
      StRun:   if (last_write) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    h_d    = h_q;
    w_d    = w_q;
    base_d = base_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    if (launch) begin
      h_d    = h;
      w_d    = w;
      base_d = base_addr;
      idx_d  = '0;
      acc_d  = '0;
      x_d    = '0;
      y_d    = '0;
    end else begin
      if (push) acc_d = acc_q + (2*WORD)'(1);
      if (pop) begin
        idx_d = idx_q + 32'd1;
        if (x_q == w_q - WORD'(1)) begin
          x_d = '0;
          y_d = y_q + WORD'(1);
        end else begin
          x_d = x_q + WORD'(1);
        end
      end
    end
    total = (2*WORD)'(h_d) * (2*WORD)'(w_d);
  end

  always_comb begin
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    row_end_d   = pop && (x_q == w_q - WORD'(1));
    w_en_d      = (state_d == StRun) && (fifo_count_next != 2'd0);
    res_ready_d = (state_d == StRun) && (32'(fifo_count_next) < FIFO_DEPTH) && (acc_d < total);
    address_d   = w_en_d ? base_d + idx_d * ADDR_STRIDE : '0;
    wdata_d     = w_en_d ? 32'(fifo_head_next) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      w_q         <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_ready_q <= 1'b0;
      w_en_q      <= 1'b0;
      row_end_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      w_q         <= w_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_ready_q <= res_ready_d;
      w_en_q      <= w_en_d;
      row_end_q   <= row_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
    end
  end

  assign res_ready = res_ready_q;
  assign w_en      = w_en_q;
  assign row_end   = row_end_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign address   = address_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: a transaction-level model checked every cycle,
// plus literal expectations for each directed frame.
module tb_result_writer;

  logic        clk = 1'b0;
  logic        rst, start, res_valid, res_ready, w_en, mem_ready, row_end, busy, done;
  logic [7:0]  h, w, res_data;
  logic [31:0] base_addr, address, wdata;

  int checks = 0;
  int failures = 0;

  result_writer #(
    .WORD        (8),
    .ADDR_STRIDE (4),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h         (h),
    .w         (w),
    .base_addr (base_addr),
    .start     (start),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .address   (address),
    .wdata     (wdata),
    .w_en      (w_en),
    .mem_ready (mem_ready),
    .row_end   (row_end),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame as a list of accepted pixels and a count of completed writes.
  bit          m_valid = 0, m_busy, m_run, m_done_now, m_row_now;
  int          m_acc, m_wr, m_total, m_w;
  logic [31:0] m_base;
  int          q[$];
  int          n_done = 0, n_row_end = 0, n_wen = 0, n_rr = 0, n_writes = 0;
  logic [31:0] log_addr[$];
  int          log_data[$];

  always @(negedge clk) begin
    bit e_wen, e_rr, nxt_row, nxt_done;
    e_wen = m_run && (q.size() > 0);
    e_rr  = m_run && (q.size() < 2) && (m_acc < m_total);
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done_now));
      chk("row_end", 32'(row_end), 32'(m_row_now));
      chk("w_en", 32'(w_en), 32'(e_wen));
      chk("res_ready", 32'(res_ready), 32'(e_rr));
      if (e_wen) begin
        chk("address", address, m_base + 32'(4 * m_wr));
        chk("wdata", wdata, 32'(q[0]));
      end
    end
    if (w_en === 1'b1) n_wen++;
    if (res_ready === 1'b1) n_rr++;
    if (done === 1'b1) n_done++;
    if (row_end === 1'b1) n_row_end++;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_run = 0; m_done_now = 0; m_row_now = 0;
      m_acc = 0; m_wr = 0; m_total = 0; m_w = 1; m_base = 0;
      q.delete();
    end else if (m_valid) begin
      nxt_row = 0;
      nxt_done = 0;
      if (m_run) begin
        if (e_wen && mem_ready) begin
          log_addr.push_back(address);
          log_data.push_back(int'(wdata));
          void'(q.pop_front());
          m_wr++;
          n_writes++;
          if (m_wr % m_w == 0) nxt_row = 1;
          if (m_wr == m_total) begin
            m_run = 0;
            nxt_done = 1;
          end
        end
        if (e_rr && res_valid) begin
          q.push_back(int'(res_data));
          m_acc++;
        end
      end else if (m_done_now) begin
        m_busy = 0;
      end else if (!m_busy && start) begin
        m_busy = 1;
        if ($signed(h) <= 0 || $signed(w) <= 0) begin
          nxt_done = 1;
        end else begin
          m_run = 1; m_acc = 0; m_wr = 0;
          m_total = int'($signed(h)) * int'($signed(w));
          m_w = int'($signed(w));
          m_base = base_addr;
          q.delete();
        end
      end
      m_done_now = nxt_done;
      m_row_now = nxt_row;
    end
  end

  // Source and memory stall control, advanced one cycle per step().
  bit          src_on;
  int          src_left, src_data, stall_left, n_stall, f_cycles;
  bit          rr_low;
  logic [31:0] stall_addr;
  int          f_done, f_rows, f_wen, f_rr;

  task automatic step();
    bit fire;
    @(negedge clk);
    fire = res_valid && res_ready;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (fire) begin
      src_left--;
      src_data++;
    end
    res_valid = src_on && (src_left > 0);
    res_data  = 8'(src_data);
    if (stall_left > 0 && w_en && address == stall_addr) begin
      mem_ready = 1'b0;
      stall_left--;
      n_stall++;
      if (!res_ready) rr_low = 1;
    end else begin
      mem_ready = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_w_en"}, 32'(w_en), 0);
    chk({tag, "_res_ready"}, 32'(res_ready), 0);
    chk({tag, "_row_end"}, 32'(row_end), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  task automatic run_frame(input int hh, input int ww, input logic [31:0] base, input int offers,
                           input logic [31:0] st_addr, input int st_n, input int inj,
                           input int rst_after, input int budget);
    int done0, row0, wen0, rr0;
    bit did_rst;
    done0 = n_done; row0 = n_row_end; wen0 = n_wen; rr0 = n_rr; did_rst = 0;
    n_writes = 0;
    log_addr.delete();
    log_data.delete();
    stall_addr = st_addr; stall_left = st_n; n_stall = 0; rr_low = 0;
    h = 8'(hh); w = 8'(ww); base_addr = base; start = 1'b1;
    src_on = 1; src_left = offers; src_data = 10;
    res_valid = (offers > 0); res_data = 8'd10;
    step();
    f_cycles = 0;
    while (n_done == done0 && f_cycles < budget && !did_rst) begin
      if (inj != 0 && f_cycles == inj) begin
        start = 1'b1; h = 8'd4; w = 8'd4; base_addr = 32'h900;
      end
      if (rst_after != 0 && n_writes == rst_after) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        did_rst = 1;
        check_all_zero("midrst");
      end else begin
        step();
      end
      f_cycles++;
    end
    if (!did_rst) chk("frame_done_seen", 32'(n_done - done0), 1);
    src_on = 0;
    res_valid = 1'b0;
    step();
    step();
    f_done = n_done - done0; f_rows = n_row_end - row0; f_wen = n_wen - wen0; f_rr = n_rr - rr0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; h = '0; w = '0; base_addr = '0;
    res_valid = 1'b0; res_data = '0; mem_ready = 1'b1;
    src_on = 0; src_left = 0; src_data = 0; stall_left = 0; stall_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset");
    step();

    // Nominal 2x3 frame.
    run_frame(2, 3, 32'h100, 6, 32'h0, 0, 0, 0, 40);
    chk("nom_writes", 32'(n_writes), 6);
    for (int i = 0; i < 6; i++) begin
      chk("nom_addr", (i < log_addr.size()) ? log_addr[i] : 32'hdead, 32'h100 + 32'(4 * i));
      chk("nom_data", (i < log_data.size()) ? 32'(log_data[i]) : 32'hdead, 32'(10 + i));
    end
    chk("nom_row_ends", 32'(f_rows), 2);
    chk("nom_done_pulses", 32'(f_done), 1);
    chk("nom_busy_after", 32'(busy), 0);

    // Backpressure on the second pixel.
    run_frame(2, 3, 32'h100, 6, 32'h104, 4, 0, 0, 60);
    chk("bp_stall_cycles", 32'(n_stall), 4);
    chk("bp_rr_fell", 32'(rr_low), 1);
    chk("bp_writes", 32'(n_writes), 6);
    for (int i = 0; i < 6; i++)
      chk("bp_data", (i < log_data.size()) ? 32'(log_data[i]) : 32'hdead, 32'(10 + i));

    // Degenerate width.
    run_frame(5, 0, 32'h100, 4, 32'h0, 0, 0, 0, 3);
    chk("degen_done", 32'(f_done), 1);
    chk("degen_fast", 32'(f_cycles <= 2), 1);
    chk("degen_wen", 32'(f_wen), 0);
    chk("degen_rr", 32'(f_rr), 0);

    // Overrun: 8 offered, 6 accepted.
    run_frame(2, 3, 32'h100, 8, 32'h0, 0, 0, 0, 40);
    chk("overrun_accepted", 32'(8 - src_left), 6);
    chk("overrun_writes", 32'(n_writes), 6);

    // start mid-frame with different size is ignored.
    run_frame(2, 3, 32'h300, 6, 32'h0, 0, 4, 0, 40);
    chk("inj_writes", 32'(n_writes), 6);
    chk("inj_last_addr", (log_addr.size() == 6) ? log_addr[5] : 32'hdead, 32'h314);

    // Address wrap past 2^32.
    run_frame(1, 3, 32'hFFFF_FFF8, 3, 32'h0, 0, 0, 0, 20);
    chk("wrap_addr2", (log_addr.size() == 3) ? log_addr[2] : 32'hdead, 32'h0);

    // Reset after three writes, then a 1x1 frame.
    run_frame(2, 3, 32'h100, 6, 32'h0, 0, 0, 3, 40);
    chk("rst_no_done", 32'(f_done), 0);
    run_frame(1, 1, 32'h200, 1, 32'h0, 0, 0, 0, 20);
    chk("one_addr", (log_addr.size() == 1) ? log_addr[0] : 32'hdead, 32'h200);
    chk("one_data", (log_data.size() == 1) ? 32'(log_data[0]) : 32'hdead, 32'd10);
    chk("one_row_end", 32'(f_rows), 1);
    chk("one_done", 32'(f_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
